// File: rtl/nco_freq_meter.sv
// nco_freq_meter: measures a square wave's rising-edge rate over a gapless
// 2^GATE_LOG2-cycle gate and reports it as an equivalent NCO tuning word.
module nco_freq_meter #(
    parameter int ACC_BITS  = 16,
    parameter int GATE_LOG2 = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                signal,
    output logic [ACC_BITS-1:0] fcw_est,
    output logic                valid,
    input  logic                ready,
    output logic                overrun
);

    localparam int SHIFT = ACC_BITS - GATE_LOG2;
    localparam logic [GATE_LOG2-1:0] GATE_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        COUNT
    } state_t;

    state_t state_q, state_d;

    logic [GATE_LOG2-1:0] gate_q, gate_d;
    logic [GATE_LOG2-1:0] cnt_q, cnt_d;
    logic [GATE_LOG2-1:0] cnt_inc;

    logic sync1_q, sync2_q, sync3_q;
    logic edge_q;

    logic [ACC_BITS-1:0] fcw_q, fcw_d;
    logic [ACC_BITS-1:0] result;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic                publish;

    // Synchronize the async input and flag each synchronized 0->1 step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= signal;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;
        end
    end

    // The edge seen on the final gate cycle still belongs to this window.
    assign cnt_inc = cnt_q + GATE_LOG2'(edge_q);
    assign result  = ACC_BITS'(cnt_inc) << SHIFT;

    // Gate sequencing: arm on an edge, then back-to-back windows.
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        publish = 1'b0;
        unique case (state_q)
            IDLE: begin
                gate_d = '0;
                cnt_d  = '0;
                if (en) state_d = ARM;
            end
            ARM: begin
                gate_d = '0;
                cnt_d  = '0;
                if (!en) state_d = IDLE;
                else if (edge_q) state_d = COUNT;
            end
            COUNT: begin
                if (!en) begin
                    state_d = IDLE;
                    gate_d  = '0;
                    cnt_d   = '0;
                end else if (gate_q == GATE_LAST) begin
                    publish = 1'b1;
                    gate_d  = '0;
                    cnt_d   = '0;
                end else begin
                    gate_d = gate_q + GATE_LOG2'(1);
                    cnt_d  = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                gate_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Result holding register with sticky overwrite detection.
    always_comb begin
        fcw_d   = fcw_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (publish) begin
            fcw_d   = result;
            valid_d = 1'b1;
            if (valid_q) ovr_d = ~ready;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // State, counters and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gate_q  <= '0;
            cnt_q   <= '0;
            fcw_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            fcw_q   <= fcw_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign fcw_est = fcw_q;
    assign valid   = valid_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_nco_freq_meter.sv
// tb_nco_freq_meter: randomized scenarios checked against a timestamp-level
// model of gate windows built from the recorded input rising edges.
module tb_nco_freq_meter;

    localparam int AB  = 16;
    localparam int GL  = 8;
    localparam int WIN = 1 << GL;
    localparam int SCL = 1 << (AB - GL);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sig;
    logic          ready;
    logic          valid;
    logic          overrun;
    logic [AB-1:0] fcw_est;

    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;
    int   e      = 0;
    int   p0     = -1;
    logic sig_prev;

    int rises[$];
    int obs_c[$];
    int obs_v[$];
    int exp_c[$];
    int exp_v[$];

    always #5 clk = ~clk;

    nco_freq_meter #(
        .ACC_BITS (AB),
        .GATE_LOG2(GL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .signal (sig),
        .fcw_est(fcw_est),
        .valid  (valid),
        .ready  (ready),
        .overrun(overrun)
    );

    // Count clock edges and log every accepted result with its edge index.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (valid === 1'b1 && ready === 1'b1) begin
            obs_c.push_back(cyc);
            obs_v.push_back(int'(fcw_est));
        end
    end

    // Drive the input for the next clock edge and note rising steps.
    task automatic drive(input logic v);
        if (v && !sig_prev) rises.push_back(cyc + 1);
        sig_prev = v;
        sig      = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        en       = 1'b0;
        sig      = 1'b0;
        sig_prev = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rises.delete();
        obs_c.delete();
        obs_v.delete();
    endtask

    task automatic start_en();
        @(negedge clk);
        en = 1'b1;
        e  = cyc + 1;
    endtask

    task automatic sq_run(input int n, input int per, input int ph);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(((cyc + 1 + ph) % per) >= (per / 2));
        end
    endtask

    // Model: an input rise sampled at edge k is consumed by the gate at k+3.
    // The first rise consumed after enabling arms; windows of WIN edges follow.
    task automatic build_expected();
        exp_c.delete();
        exp_v.delete();
        p0 = -1;
        foreach (rises[i])
            if (p0 < 0 && rises[i] + 3 >= e + 1) p0 = rises[i] + 3;
        if (p0 >= 0) begin
            for (int j = 0; p0 + WIN * (j + 1) <= cyc; j++) begin
                int lo;
                int hi;
                int n;
                lo = p0 + WIN * j + 1;
                hi = p0 + WIN * (j + 1);
                n  = 0;
                foreach (rises[i])
                    if (rises[i] + 3 >= lo && rises[i] + 3 <= hi) n++;
                exp_c.push_back(hi);
                exp_v.push_back(n * SCL);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests++;
        if (fcw_est !== '0 || valid !== 1'b0 || overrun !== 1'b0) begin
            failed++;
            $display("FAIL reset_init: got fcw=%0d v=%b o=%b, want 0 0 0",
                     fcw_est, valid, overrun);
        end
        do_reset();
        ready = 1'b0;
        start_en();
        sq_run(300, 16, 3);
        tests++;
        if (valid !== 1'b1) begin
            failed++;
            $display("FAIL reset_pre_valid: got %b, want 1", valid);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (fcw_est !== '0 || valid !== 1'b0 || overrun !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid: got fcw=%0d v=%b o=%b, want 0 0 0",
                     fcw_est, valid, overrun);
        end
        @(negedge clk);
        rst      = 1'b0;
        sig      = 1'b0;
        sig_prev = 1'b0;
        en       = 1'b0;
        ready    = 1'b1;
        rises.delete();
        obs_c.delete();
        obs_v.delete();
        start_en();
        sq_run(800, 16, 5);
        build_expected();
        tests++;
        if (obs_c.size() != exp_c.size() || exp_c.size() == 0) begin
            failed++;
            $display("FAIL reset_rearm count: got %0d, want %0d",
                     obs_c.size(), exp_c.size());
        end
        for (int i = 0; i < obs_c.size() && i < exp_c.size(); i++) begin
            tests++;
            if (obs_c[i] !== exp_c[i] || obs_v[i] !== exp_v[i]) begin
                failed++;
                $display("FAIL reset_rearm w%0d: got @%0d=%0d, want @%0d=%0d",
                         i, obs_c[i], obs_v[i], exp_c[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_period16();
        do_reset();
        ready = 1'b1;
        start_en();
        sq_run(1100, 16, int'($urandom_range(0, 15)));
        build_expected();
        tests++;
        if (obs_c.size() != exp_c.size() || exp_c.size() < 3) begin
            failed++;
            $display("FAIL p16 count: got %0d, want %0d",
                     obs_c.size(), exp_c.size());
        end
        for (int i = 0; i < obs_c.size() && i < exp_c.size(); i++) begin
            tests++;
            if (obs_c[i] !== exp_c[i] || obs_v[i] !== 4096) begin
                failed++;
                $display("FAIL p16 w%0d: got @%0d=%0d, want @%0d=4096",
                         i, obs_c[i], obs_v[i], exp_c[i]);
            end
        end
        tests++;
        if (overrun !== 1'b0) begin
            failed++;
            $display("FAIL p16 overrun: got %b, want 0", overrun);
        end
    endtask

    task automatic test_nco_loopback();
        logic [AB-1:0] acc;
        logic [AB-1:0] fcw;
        int            tc;
        int            want;
        do_reset();
        ready = 1'b1;
        acc   = AB'($urandom);
        fcw   = 16'd2560;
        start_en();
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            acc = acc + fcw;
            drive(acc[AB-1]);
        end
        fcw = 16'd7680;
        tc  = cyc + 1;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            acc = acc + fcw;
            drive(acc[AB-1]);
        end
        build_expected();
        tests++;
        if (obs_c.size() != exp_c.size() || exp_c.size() < 5) begin
            failed++;
            $display("FAIL nco count: got %0d, want %0d",
                     obs_c.size(), exp_c.size());
        end
        for (int i = 0; i < obs_c.size() && i < exp_c.size(); i++) begin
            want = (obs_c[i] - 3 < tc) ? 2560 :
                   (obs_c[i] >= tc + 258) ? 7680 : -1;
            tests++;
            if (obs_c[i] !== exp_c[i] || obs_v[i] !== exp_v[i] ||
                (want >= 0 && obs_v[i] !== want) ||
                (want < 0 && (obs_v[i] < 2560 || obs_v[i] > 7680))) begin
                failed++;
                $display("FAIL nco w%0d: got @%0d=%0d, want @%0d=%0d (%0d)",
                         i, obs_c[i], obs_v[i], exp_c[i], exp_v[i], want);
            end
        end
    endtask

    task automatic test_random();
        int   hold;
        logic v;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            ready = 1'b1;
            start_en();
            v    = 1'b0;
            hold = 0;
            for (int i = 0; i < 850; i++) begin
                @(negedge clk);
                if (r == 2) begin
                    v = 1'($urandom);
                end else if (hold == 0) begin
                    v    = ~v;
                    hold = int'($urandom_range(1, r == 0 ? 3 : 30));
                end
                if (hold > 0) hold--;
                drive(v);
            end
            build_expected();
            tests++;
            if (obs_c.size() != exp_c.size() || exp_c.size() == 0) begin
                failed++;
                $display("FAIL rnd%0d count: got %0d, want %0d",
                         r, obs_c.size(), exp_c.size());
            end
            for (int i = 0; i < obs_c.size() && i < exp_c.size(); i++) begin
                tests++;
                if (obs_c[i] !== exp_c[i] || obs_v[i] !== exp_v[i]) begin
                    failed++;
                    $display("FAIL rnd%0d w%0d: got @%0d=%0d, want @%0d=%0d",
                             r, i, obs_c[i], obs_v[i], exp_c[i], exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready = 1'b0;
        start_en();
        sq_run(600, 16, int'($urandom_range(0, 15)));
        tests++;
        if (valid !== 1'b1 || fcw_est !== 16'd4096 || overrun !== 1'b1) begin
            failed++;
            $display("FAIL bp_hold: got v=%b fcw=%0d o=%b, want 1 4096 1",
                     valid, fcw_est, overrun);
        end
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        tests++;
        if (valid !== 1'b0 || overrun !== 1'b0 || fcw_est !== 16'd4096) begin
            failed++;
            $display("FAIL bp_accept: got v=%b o=%b fcw=%0d, want 0 0 4096",
                     valid, overrun, fcw_est);
        end
    endtask

    task automatic test_abort();
        int ph;
        ph = int'($urandom_range(0, 31));
        do_reset();
        ready = 1'b1;
        start_en();
        sq_run(40, 32, ph);
        build_expected();
        if (p0 < 0) begin
            tests++;
            failed++;
            $display("FAIL abort_arm: got no arming edge, want one");
            return;
        end
        while (cyc < p0 + WIN + 100) sq_run(1, 32, ph);
        en = 1'b0;
        sq_run(400, 32, ph);
        tests++;
        if (obs_c.size() != 1 || fcw_est !== 16'd2048 || valid !== 1'b0 ||
            overrun !== 1'b0) begin
            failed++;
            $display("FAIL abort_hold: got n=%0d fcw=%0d v=%b o=%b, want 1 2048 0 0",
                     obs_c.size(), fcw_est, valid, overrun);
        end
        @(negedge clk);
        en = 1'b1;
        e  = cyc + 1;
        drive(1'b0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive(1'b0);
        end
        tests++;
        if (obs_c.size() != 1 || valid !== 1'b0) begin
            failed++;
            $display("FAIL abort_arm_wait: got n=%0d v=%b, want 1 0",
                     obs_c.size(), valid);
        end
        obs_c.delete();
        obs_v.delete();
        sq_run(700, 32, ph);
        build_expected();
        tests++;
        if (obs_c.size() != exp_c.size() || exp_c.size() == 0) begin
            failed++;
            $display("FAIL abort_resume count: got %0d, want %0d",
                     obs_c.size(), exp_c.size());
        end
        for (int i = 0; i < obs_c.size() && i < exp_c.size(); i++) begin
            tests++;
            if (obs_c[i] !== exp_c[i] || obs_v[i] !== 2048) begin
                failed++;
                $display("FAIL abort_resume w%0d: got @%0d=%0d, want @%0d=2048",
                         i, obs_c[i], obs_v[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_window_boundary();
        int   pk[$];
        int   k;
        int   pz;
        int   bw[3];
        logic v;
        bw = '{256, 512, 512};
        do_reset();
        ready = 1'b1;
        start_en();
        pz = e + 8;
        pk = '{e + 5, pz + 253, pz + 255, pz + 508, pz + 510, pz + 765};
        while (cyc < pz + 800) begin
            @(negedge clk);
            k = cyc + 1;
            v = 1'b0;
            foreach (pk[i]) if (pk[i] == k) v = 1'b1;
            drive(v);
        end
        build_expected();
        tests++;
        if (obs_c.size() != exp_c.size() || obs_c.size() < 3) begin
            failed++;
            $display("FAIL bnd count: got %0d, want %0d",
                     obs_c.size(), exp_c.size());
        end
        for (int i = 0; i < obs_c.size() && i < exp_c.size(); i++) begin
            tests++;
            if (obs_c[i] !== exp_c[i] || obs_v[i] !== exp_v[i] ||
                (i < 3 && obs_v[i] !== bw[i])) begin
                failed++;
                $display("FAIL bnd w%0d: got @%0d=%0d, want @%0d=%0d",
                         i, obs_c[i], obs_v[i], exp_c[i], exp_v[i]);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        ready    = 1'b1;
        sig      = 1'b0;
        sig_prev = 1'b0;
        #2;
        test_reset();
        test_period16();
        test_nco_loopback();
        test_random();
        test_backpressure();
        test_abort();
        test_window_boundary();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/nco_freq_meter.md
# nco_freq_meter

Measures the frequency of a 1-bit square wave, such as the MSB output `signal` of `nco`, and reports it as an equivalent NCO frequency control word. Rising edges are counted over a gapless gate of 2^GATE_LOG2 clock cycles, and the count is scaled to ACC_BITS. It is the receive-side counterpart of `nco`: feeding `nco` a word `fcw` and measuring its MSB returns `fcw`. Results leave on a valid/ready interface for loopback self-test and frequency monitoring.

## Interface
- ACC_BITS, 16, width of the NCO phase accumulator and of `fcw_est`
- GATE_LOG2, 16, log2 of the gate length in clk cycles; legal range 1..ACC_BITS
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  measurement enable; level-sensitive
- signal  in  1  square wave to measure; may be asynchronous
- fcw_est  out  ACC_BITS  measured frequency word = edge_count << (ACC_BITS-GATE_LOG2)
- valid  out  1  `fcw_est` holds an unconsumed result
- ready  in  1  consumer accepts the result when valid&ready
- overrun  out  1  sticky flag: an unaccepted result was overwritten

## Operation
- Input path: 2-FF synchronizer on `signal`, then a registered rising-edge detect. `edge` is high for one cycle per 0→1 transition of the synchronized signal.
- FSM states: IDLE, ARM, COUNT.
  - IDLE: counters held at 0. If en=1, go to ARM.
  - ARM: wait for `edge`. The arming edge is not counted. On `edge`, go to COUNT with gate_cnt=0 and edge_cnt=0.
  - COUNT: gate_cnt increments every cycle, and edge_cnt increments on every `edge`, including an edge in the last gate cycle.
    - On the cycle gate_cnt = 2^GATE_LOG2-1, publish the result. gate_cnt and edge_cnt restart at 0 on the next cycle with no gap, and the FSM stays in COUNT.
    - An edge on that last cycle belongs to the finishing window. An edge on the next cycle belongs to the new window.
- en=0 in ARM or COUNT: go to IDLE next cycle and clear counters. No result is published, and `fcw_est`, `valid` and `overrun` hold.
- Widths and arithmetic:
  - edge_cnt is GATE_LOG2 bits wide.
  - The synchronized input gives at most 2^(GATE_LOG2-1) edges per window, so the scaled result is at most 2^(ACC_BITS-1). No saturation logic is required.
  - The shift is a left shift by ACC_BITS-GATE_LOG2; it is 0 when GATE_LOG2 = ACC_BITS.
- Publish:
  - `fcw_est` is loaded and `valid` is set to 1.
  - If valid=1 and ready=0 in the publish cycle, the old value is overwritten and `overrun` is set to 1.
- Handshake:
  - `valid` stays high until a cycle with valid&ready, then clears on the next cycle, unless a publish happens in that same cycle, in which case `valid` stays 1 and `fcw_est` takes the new value.
  - `overrun` clears on a handshake cycle that has no simultaneous overwrite. It is not cleared by `en`.
- Reset (any time, including mid-window):
  - Outputs: fcw_est=0, valid=0, overrun=0.
  - Internal: state=IDLE, counters 0, synchronizer and edge registers 0.
  - A rising `signal` present at reset release produces an edge after the sync latency; this is legal.

## Timing
- Input to `edge` latency: 3 cycles (2 synchronizer stages plus the edge register).
- Window length: exactly 2^GATE_LOG2 cycles, back-to-back.
- The first window starts the cycle after the arming `edge`.
- `valid`/`fcw_est` update registered, 1 cycle after the last gate cycle.
- First result after en rises: about 1 + 3 + time to the first edge + 2^GATE_LOG2 + 1 cycles.
- `ready` has no combinational path to any output.

## Test plan
- Reset: assert rst mid-COUNT with valid=1 → fcw_est=0, valid=0, overrun=0 immediately; after release with en=1, the FSM re-arms and the next result is correct.
- Period-16 square wave, GATE_LOG2=8, ready=1 → every window gives 16 edges, so fcw_est=4096, with valid pulses exactly 256 cycles apart.
- Loopback from `nco`, default parameters, fcw=10, en=1, ready=1 → every result is 10. Change fcw to 30 → the first window fully after the change reports 30, and a window straddling the change reports a value between 10 and 30.
- Backpressure: period-16 input, GATE_LOG2=8, ready=0 for 600 cycles → valid=1 with fcw_est=4096 and overrun=1 after the second publish. Raise ready for 1 cycle with no publish → valid=0 and overrun=0 next cycle.
- Abort: drop en at gate_cnt=100 → IDLE next cycle, no valid pulse, previous fcw_est retained. Re-raise en → ARM waits for a new edge.
- Edge at window boundary: input with edges placed on the last gate cycle and on the first cycle of the next window → the last-cycle edge is counted in the finishing window and the other in the new window; no edge is double-counted or lost.
